// File: rtl/i2s_pkg.sv
// Shared I2S types: receiver FSM states, channel tags and the default sample width.
package i2s_pkg;
  typedef enum logic [1:0] {ALIGN, DELAY, SHIFT, PAD} i2s_rx_state_t;
  typedef enum logic {CH_LEFT, CH_RIGHT} i2s_ch_t;
  localparam int I2S_DW_DEFAULT = 24;
endpackage

// File: rtl/i2s_edge_det.sv
// Edge detector for one I2S control line; optional 2-flop synchronizer when I2S_RX_SYNC_EN is defined.
module i2s_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic fall
);
  logic lvl;
  logic prev_q, prev_d;

`ifdef I2S_RX_SYNC_EN
  logic [1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[0], din};
  always_ff @(posedge clk) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= sync_d;
  end
  assign lvl = sync_q[1];
`else
  assign lvl = din;
`endif

  always_comb prev_d = lvl;
  always_ff @(posedge clk) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= prev_d;
  end

  assign rise = lvl & ~prev_q;
  assign fall = ~lvl & prev_q;
endmodule

// File: rtl/i2s_rx.sv
// I2S receiver: oversamples sclk/lrclk/sdata in the clk domain and emits {left,right} frames on valid/ready.
// Define I2S_RX_SYNC_EN to add 2-flop input synchronizers for an asynchronous codec clock.
module i2s_rx
  import i2s_pkg::*;
#(
  parameter int DW       = I2S_DW_DEFAULT,
  parameter int MIN_SCLK = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            sclk,
  input  logic            lrclk,
  input  logic            sdata,
  output logic [2*DW-1:0] m_tdata,
  output logic            m_tvalid,
  input  logic            m_tready,
  output logic            overrun,
  output logic            short_err
);
  localparam int CW = $clog2(DW + 1);

  logic sclk_rise, sclk_fall, lr_rise, lr_fall, lr_edge, sdata_s;

  i2s_edge_det u_sclk_det (.clk(clk), .rst(rst), .din(sclk),  .rise(sclk_rise), .fall(sclk_fall));
  i2s_edge_det u_lr_det   (.clk(clk), .rst(rst), .din(lrclk), .rise(lr_rise),   .fall(lr_fall));

  // sdata is delayed exactly like the clocks so bits stay aligned with sclk_rise.
`ifdef I2S_RX_SYNC_EN
  logic [1:0] sdata_sync_q, sdata_sync_d;
  always_comb sdata_sync_d = {sdata_sync_q[0], sdata};
  always_ff @(posedge clk) begin
    if (!rst) sdata_sync_q <= '0;
    else      sdata_sync_q <= sdata_sync_d;
  end
  assign sdata_s = sdata_sync_q[1];
`else
  assign sdata_s = sdata;
`endif

  assign lr_edge = lr_rise | lr_fall;

  i2s_rx_state_t   state_q, state_d;
  logic [DW-1:0]   shreg_q, shreg_d, left_q, left_d, closed_word;
  logic [CW-1:0]   bitcnt_q, bitcnt_d;
  logic [2*DW-1:0] frame_q, frame_d, tdata_q, tdata_d;
  logic            fvld_q, fvld_d, tvalid_q, tvalid_d;
  logic            ovr_q, ovr_d, short_q, short_d;
  i2s_ch_t         close_ch;

  // Partial words are left-justified so a short slot reads as a truncated sample.
  assign closed_word = shreg_q << (CW'(DW) - bitcnt_q);
  assign close_ch    = lr_fall ? CH_RIGHT : CH_LEFT;

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    left_d   = left_q;
    frame_d  = frame_q;
    fvld_d   = 1'b0;
    short_d  = 1'b0;
    if (state_q == ALIGN) begin
      if (lr_fall) begin
        state_d  = sclk_rise ? SHIFT : DELAY;
        shreg_d  = '0;
        bitcnt_d = '0;
      end
    end else if (lr_edge) begin
      // A coincident sclk_rise is the delay bit of the new slot.
      short_d = (bitcnt_q < CW'(DW));
      if (close_ch == CH_LEFT) begin
        left_d = closed_word;
      end else begin
        frame_d = {left_q, closed_word};
        fvld_d  = 1'b1;
      end
      state_d  = sclk_rise ? SHIFT : DELAY;
      shreg_d  = '0;
      bitcnt_d = '0;
    end else if (sclk_rise) begin
      case (state_q)
        DELAY: state_d = SHIFT;
        SHIFT: begin
          if (bitcnt_q != CW'(DW)) begin
            shreg_d  = {shreg_q[DW-2:0], sdata_s};
            bitcnt_d = bitcnt_q + 1'b1;
          end
          if (bitcnt_q >= CW'(DW - 1)) state_d = PAD;
        end
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    ovr_d    = 1'b0;
    if (tvalid_q && m_tready) tvalid_d = 1'b0;
    if (fvld_q) begin
      if (!tvalid_q || m_tready) begin
        tdata_d  = frame_q;
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ALIGN;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      left_q   <= '0;
      frame_q  <= '0;
      fvld_q   <= 1'b0;
      short_q  <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      left_q   <= left_d;
      frame_q  <= frame_d;
      fvld_q   <= fvld_d;
      short_q  <= short_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign overrun   = ovr_q;
  assign short_err = short_q;

  // Cycles since the last sclk edge, saturating; only feeds the half-period check.
  logic [7:0] gap_q, gap_d;
  always_comb begin
    gap_d = gap_q;
    if (sclk_rise || sclk_fall) gap_d = '0;
    else if (gap_q != 8'hFF)    gap_d = gap_q + 8'd1;
  end
  always_ff @(posedge clk) begin
    if (!rst) gap_q <= 8'hFF;
    else      gap_q <= gap_d;
  end

  a_sclk_half: assert property (@(posedge clk) disable iff (!rst)
    (sclk_rise || sclk_fall) |-> (int'(gap_q) >= MIN_SCLK - 1));
endmodule

// File: tb/tb_i2s_rx.sv
// Directed bench for i2s_rx: a BFM drives sclk/lrclk/sdata (32-bit slots, sclk = clk/4).
module tb_i2s_rx;
  localparam int DW = 24;
`ifdef I2S_RX_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  logic            clk = 1'b0;
  logic            rst, sclk, lrclk, sdata, m_tready;
  logic [2*DW-1:0] m_tdata;
  logic            m_tvalid, overrun, short_err;

  i2s_rx #(.DW(DW), .MIN_SCLK(2)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .lrclk(lrclk), .sdata(sdata),
    .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tready(m_tready),
    .overrun(overrun), .short_err(short_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  int short_cnt = 0;

  always @(negedge clk) begin
    if (overrun === 1'b1)   ovr_cnt++;
    if (short_err === 1'b1) short_cnt++;
  end

  logic            vh [1:4];
  logic [2*DW-1:0] dh [1:4];

  task automatic chk(input string tag, input logic [2*DW-1:0] obs, input logic [2*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One bit period, entered and left on a negedge: sclk low 2 clk, high 2 clk.
  task automatic bit_out(input logic lr, input logic d);
    sclk = 1'b0; lrclk = lr; sdata = d;
    repeat (2) @(negedge clk);
    sclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Delay bit of a left slot (lrclk falls); records m_tvalid/m_tdata for 4 clk after the fall.
  task automatic left_start();
    sclk = 1'b0; lrclk = 1'b0; sdata = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vh[k] = m_tvalid;
      dh[k] = m_tdata;
      if (k == 2) sclk = 1'b1;
    end
  endtask

  task automatic send_data(input logic lr, input logic [DW-1:0] val, input int nbits, input int npad);
    for (int i = 0; i < nbits; i++) bit_out(lr, val[DW-1-i]);
    for (int i = 0; i < npad; i++)  bit_out(lr, 1'b0);
  endtask

  task automatic frame(input logic [DW-1:0] l, input logic [DW-1:0] r);
    send_data(1'b0, l, DW, 7);
    bit_out(1'b1, 1'b0);
    send_data(1'b1, r, DW, 7);
  endtask

  int ovr0, sh0;

  initial begin
    rst = 1'b0; sclk = 1'b0; lrclk = 1'b1; sdata = 1'b0; m_tready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_tvalid",    {47'd0, m_tvalid},  48'd0);
    chk("rst_tdata",     m_tdata,            48'd0);
    chk("rst_overrun",   {47'd0, overrun},   48'd0);
    chk("rst_short_err", {47'd0, short_err}, 48'd0);

    // Released mid-right-slot: the partial frame must be ignored.
    rst = 1'b1;
    repeat (5) bit_out(1'b1, 1'b1);
    left_start();
    chk("align_no_valid", {47'd0, vh[LAT]}, 48'd0);
    sh0 = short_cnt;

    frame(24'hA5A5A5, 24'h123456);
    left_start();
    chk("loop_lat_early", {47'd0, vh[LAT-1]}, 48'd0);
    chk("loop_lat_valid", {47'd0, vh[LAT]},   48'd1);
    chk("loop_data",      dh[LAT],            48'hA5A5A5_123456);
    chk("loop_no_short",  short_cnt - sh0,    48'd0);

    // Backpressure: first frame held, next two dropped.
    m_tready = 1'b0;
    ovr0 = ovr_cnt;
    frame(24'h111111, 24'h222222);
    left_start();
    chk("bp_first_valid", {47'd0, vh[LAT]}, 48'd1);
    chk("bp_first_data",  dh[LAT],          48'h111111_222222);
    frame(24'h333333, 24'h444444);
    left_start();
    frame(24'h555555, 24'h666666);
    left_start();
    chk("bp_held_valid", {47'd0, m_tvalid}, 48'd1);
    chk("bp_held_data",  m_tdata,           48'h111111_222222);
    chk("bp_overruns",   ovr_cnt - ovr0,    48'd2);
    m_tready = 1'b1;
    @(negedge clk);
    chk("bp_drained", {47'd0, m_tvalid}, 48'd0);

    // Short left slot of 20 bits.
    sh0 = short_cnt;
    send_data(1'b0, 24'hABCDE0, 20, 0);
    bit_out(1'b1, 1'b0);
    send_data(1'b1, 24'h0F0F0F, DW, 7);
    m_tready = 1'b0;
    left_start();
    chk("short_valid", {47'd0, vh[LAT]}, 48'd1);
    chk("short_data",  dh[LAT],          48'hABCDE0_0F0F0F);
    chk("short_pulse", short_cnt - sh0,  48'd1);

    // 1-clk reset mid left slot while a frame is pending.
    send_data(1'b0, 24'h777777, 10, 0);
    chk("pre_rst_held", {47'd0, m_tvalid}, 48'd1);
    sh0 = short_cnt;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    chk("mid_rst_tvalid", {47'd0, m_tvalid}, 48'd0);
    chk("mid_rst_tdata",  m_tdata,           48'd0);
    m_tready = 1'b1;
    send_data(1'b0, 24'h777777, 14, 7);
    bit_out(1'b1, 1'b0);
    send_data(1'b1, 24'h888888, DW, 7);
    left_start();
    chk("post_rst_no_valid", {47'd0, vh[LAT]}, 48'd0);
    frame(24'h999999, 24'h5A5A5A);
    left_start();
    chk("post_rst_valid", {47'd0, vh[LAT]}, 48'd1);
    chk("post_rst_data",  dh[LAT],          48'h999999_5A5A5A);
    chk("post_rst_no_short", short_cnt - sh0, 48'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
